// File: rtl/fifo_reader_pkg.sv
// fifo_reader_pkg: shared types and constants for the fifo_reader read engine.
//   state_e      - IDLE / BURST / DRAIN controller states
//   OBUF_DEPTH   - entries in the output re-timing buffer
//   RD_COUNT_W   - width of the delivered-word statistics counter
//   obuf_ptr_inc - wrap-around pointer increment for the output buffer
package fifo_reader_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BURST = 2'd1,
    DRAIN = 2'd2
  } state_e;

  localparam int OBUF_DEPTH = 3;
  localparam int RD_COUNT_W = 16;

  function automatic logic [1:0] obuf_ptr_inc(input logic [1:0] p);
    return (p == 2'(OBUF_DEPTH - 1)) ? 2'd0 : p + 2'd1;
  endfunction

endpackage

// File: rtl/fifo_reader_obuf.sv
// fifo_reader_obuf: 3-entry circular buffer holding {last, data} words between
// the FIFO read port and the output stream.
// Ports:
//   clk, rst             - clock, async active-high reset
//   push_i               - write {push_last_i, push_data_i} at the edge
//   push_data_i          - word to store
//   push_last_i          - end-of-burst tag for that word
//   pop_i                - drop the head entry at the edge
//   head_data_o          - data of the oldest entry
//   head_last_o          - tag of the oldest entry
//   occ_o                - number of valid entries (0..3)
module fifo_reader_obuf
  import fifo_reader_pkg::*;
#(
  parameter int NUM_BITS = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                push_i,
  input  logic [NUM_BITS-1:0] push_data_i,
  input  logic                push_last_i,
  input  logic                pop_i,
  output logic [NUM_BITS-1:0] head_data_o,
  output logic                head_last_o,
  output logic [1:0]          occ_o
);

  logic [NUM_BITS:0] mem_q [OBUF_DEPTH];
  logic [1:0]        wr_ptr_q;
  logic [1:0]        rd_ptr_q;
  logic [1:0]        occ_q;
  logic [1:0]        occ_d;

  always_comb begin
    occ_d = occ_q;
    unique case ({push_i, pop_i})
      2'b10:   occ_d = occ_q + 2'd1;
      2'b01:   occ_d = occ_q - 2'd1;
      default: occ_d = occ_q;
    endcase
  end

  // Entries are cleared on reset so the stream data output reads zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < OBUF_DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
    end else begin
      if (push_i) begin
        mem_q[wr_ptr_q] <= {push_last_i, push_data_i};
        wr_ptr_q        <= obuf_ptr_inc(wr_ptr_q);
      end
      if (pop_i) rd_ptr_q <= obuf_ptr_inc(rd_ptr_q);
      occ_q <= occ_d;
    end
  end

  assign head_data_o = mem_q[rd_ptr_q][NUM_BITS-1:0];
  assign head_last_o = mem_q[rd_ptr_q][NUM_BITS];
  assign occ_o       = occ_q;

endmodule

// File: rtl/fifo_reader.sv
// fifo_reader: burst read engine for a synchronous FIFO. Pops words in bursts
// and re-times them onto a valid/ready stream with a per-burst last marker.
// Optional feature macro: FIFO_READER_STATS_EN adds the rd_count output.
// Ports:
//   clk, rst       - clock, async active-high reset
//   enable         - allow full bursts of BURST_LEN words
//   flush          - allow a short burst of whatever the FIFO holds
//   fifo_empty     - FIFO empty flag
//   fifo_counter   - FIFO occupancy
//   fifo_out       - FIFO read data, valid the cycle after a pop
//   fifo_rd_en     - FIFO pop request
//   m_data/m_valid/m_ready/m_last - output stream
//   busy           - controller not in IDLE
//   rd_count       - words delivered, wrapping (FIFO_READER_STATS_EN only)
//
// state | meaning
// IDLE  | waiting for enable (full burst) or flush (short burst)
// BURST | issuing pops until len words have been requested
// DRAIN | waiting for in-flight and buffered words to leave
module fifo_reader
  import fifo_reader_pkg::*;
#(
  parameter int NUM_BITS  = 32,
  parameter int DEPTH     = 8,
  parameter int CNT_W     = 4,
  parameter int BURST_LEN = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  input  logic                  flush,
  input  logic                  fifo_empty,
  input  logic [CNT_W-1:0]      fifo_counter,
  input  logic [NUM_BITS-1:0]   fifo_out,
  output logic                  fifo_rd_en,
  output logic [NUM_BITS-1:0]   m_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic                  m_last,
  output logic                  busy
`ifdef FIFO_READER_STATS_EN
  ,
  output logic [RD_COUNT_W-1:0] rd_count
`endif
);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   len_q, len_d;
  logic [CNT_W-1:0]   issued_q, issued_d;
  logic               inflight_q;
  logic               inflight_last_q;
  logic               rd_en;
  logic               pop_last;
  logic [1:0]         obuf_occ;
  logic [NUM_BITS-1:0] head_data;
  logic               head_last;
  logic               xfer;

  always_comb begin
    state_d  = state_q;
    len_d    = len_q;
    issued_d = issued_q;
    rd_en    = 1'b0;
    unique case (state_q)
      IDLE: begin
        issued_d = '0;
        if (enable && (fifo_counter >= CNT_W'(BURST_LEN))) begin
          state_d = BURST;
          len_d   = CNT_W'(BURST_LEN);
        end else if (flush && !fifo_empty) begin
          state_d = BURST;
          len_d   = (fifo_counter > CNT_W'(DEPTH)) ? CNT_W'(DEPTH) : fifo_counter;
        end
      end
      BURST: begin
        // Pops are throttled so every requested word has a free buffer slot.
        rd_en = !fifo_empty && (issued_q < len_q) &&
                (({1'b0, obuf_occ} + {2'b00, inflight_q}) < 3'(OBUF_DEPTH));
        if (rd_en) issued_d = issued_q + CNT_W'(1);
        if (issued_d == len_q) state_d = DRAIN;
      end
      DRAIN: begin
        if ((obuf_occ == 2'd0) && !inflight_q) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // The last marker is attached at pop time; FIFO order carries it to the
  // word with delivered index len-1.
  assign pop_last = rd_en && (issued_q == (len_q - CNT_W'(1)));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q         <= IDLE;
      len_q           <= '0;
      issued_q        <= '0;
      inflight_q      <= 1'b0;
      inflight_last_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      len_q           <= len_d;
      issued_q        <= issued_d;
      inflight_q      <= rd_en;
      inflight_last_q <= pop_last;
    end
  end

  fifo_reader_obuf #(
    .NUM_BITS (NUM_BITS)
  ) u_obuf (
    .clk         (clk),
    .rst         (rst),
    .push_i      (inflight_q),
    .push_data_i (fifo_out),
    .push_last_i (inflight_last_q),
    .pop_i       (xfer),
    .head_data_o (head_data),
    .head_last_o (head_last),
    .occ_o       (obuf_occ)
  );

  assign m_valid    = (obuf_occ != 2'd0);
  assign m_data     = head_data;
  assign m_last     = m_valid && head_last;
  assign xfer       = m_valid && m_ready;
  assign fifo_rd_en = rd_en;
  assign busy       = (state_q != IDLE);

`ifdef FIFO_READER_STATS_EN
  logic [RD_COUNT_W-1:0] rd_count_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)       rd_count_q <= '0;
    else if (xfer) rd_count_q <= rd_count_q + RD_COUNT_W'(1);
  end

  assign rd_count = rd_count_q;
`endif

endmodule

// File: tb/tb_fifo_reader.sv
module tb_fifo_reader;
  localparam int NUM_BITS  = 32;
  localparam int DEPTH     = 8;
  localparam int CNT_W     = 4;
  localparam int BURST_LEN = 4;

  logic                clk;
  logic                rst;
  logic                enable;
  logic                flush;
  logic                fifo_empty;
  logic [CNT_W-1:0]    fifo_counter;
  logic [NUM_BITS-1:0] fifo_out;
  logic                fifo_rd_en;
  logic [NUM_BITS-1:0] m_data;
  logic                m_valid;
  logic                m_ready;
  logic                m_last;
  logic                busy;
`ifdef FIFO_READER_STATS_EN
  logic [15:0]         rd_count;
`endif

  int checks = 0;
  int errors = 0;

  fifo_reader #(
    .NUM_BITS  (NUM_BITS),
    .DEPTH     (DEPTH),
    .CNT_W     (CNT_W),
    .BURST_LEN (BURST_LEN)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .enable       (enable),
    .flush        (flush),
    .fifo_empty   (fifo_empty),
    .fifo_counter (fifo_counter),
    .fifo_out     (fifo_out),
    .fifo_rd_en   (fifo_rd_en),
    .m_data       (m_data),
    .m_valid      (m_valid),
    .m_ready      (m_ready),
    .m_last       (m_last),
    .busy         (busy)
`ifdef FIFO_READER_STATS_EN
    ,
    .rd_count     (rd_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural synchronous FIFO feeding the reader.
  logic [31:0] fmem [8];
  logic [2:0]  fwp, frp;
  logic [3:0]  fcnt;
  logic        wr_en;
  logic [31:0] wr_data;
  logic        do_wr, do_rd;

  assign do_wr = wr_en && (fcnt != 4'd8);
  assign do_rd = fifo_rd_en && (fcnt != 4'd0);

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      fwp <= '0; frp <= '0; fcnt <= '0; fifo_out <= '0;
    end else begin
      if (do_wr) begin fmem[fwp] <= wr_data; fwp <= fwp + 3'd1; end
      if (do_rd) begin fifo_out <= fmem[frp]; frp <= frp + 3'd1; end
      fcnt <= fcnt + 4'(do_wr) - 4'(do_rd);
    end
  end

  assign fifo_empty   = (fcnt == 4'd0);
  assign fifo_counter = fcnt;

  // Stream monitor.
  logic [31:0] got_d [$];
  bit          got_l [$];
  int          rd_pops   = 0;
  int          underflow = 0;

  always @(negedge clk) begin
    if (!rst) begin
      if (fifo_rd_en) rd_pops++;
      if (fifo_rd_en && fifo_empty) underflow++;
      if (m_valid && m_ready) begin
        got_d.push_back(m_data);
        got_l.push_back(m_last);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_words(input logic [31:0] first, input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      wr_en   = 1'b1;
      wr_data = first + 32'(i);
    end
    @(posedge clk); #1;
    wr_en = 1'b0;
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if ({fifo_rd_en, m_valid, m_last, busy} !== 4'b0000 || m_data !== 32'd0) begin
      errors++;
      $display("FAIL reset_outputs rd_en=%b valid=%b last=%b busy=%b data=%h, want all 0",
               fifo_rd_en, m_valid, m_last, busy, m_data);
    end
`ifdef FIFO_READER_STATS_EN
    checks++;
    if (rd_count !== 16'd0) begin
      errors++;
      $display("FAIL reset_rd_count got %0d want 0", rd_count);
    end
`endif
  endtask

  task automatic test_full_burst();
    bit [11:0] rd_h, v_h, b_h;
    got_d.delete(); got_l.delete();
    m_ready = 1'b1;
    write_words(32'd1, 4);
    enable = 1'b1;
    @(posedge clk);
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      rd_h[i] = fifo_rd_en; v_h[i] = m_valid; b_h[i] = busy;
    end
    tick(); enable = 1'b0;
    checks++;
    if (rd_h !== 12'b0000_0000_1111) begin
      errors++; $display("FAIL full_rd_en_pattern got %b want %b", rd_h, 12'b0000_0000_1111);
    end
    checks++;
    if (v_h !== 12'b0000_0011_1100) begin
      errors++; $display("FAIL full_valid_pattern got %b want %b", v_h, 12'b0000_0011_1100);
    end
    checks++;
    if (b_h !== 12'b0000_0111_1111) begin
      errors++; $display("FAIL full_busy_pattern got %b want %b", b_h, 12'b0000_0111_1111);
    end
    checks++;
    if (got_d.size() != 4) begin
      errors++; $display("FAIL full_count got %0d words want 4", got_d.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (got_d[i] !== 32'(i + 1) || got_l[i] !== (i == 3)) begin
          errors++;
          $display("FAIL full_word%0d got %0d/last=%b want %0d/last=%b",
                   i, got_d[i], got_l[i], i + 1, (i == 3));
        end
      end
    end
  endtask

  task automatic test_flush_short();
    int pops0;
    got_d.delete(); got_l.delete();
    m_ready = 1'b1;
    enable  = 1'b1;
    pops0   = rd_pops;
    write_words(32'd5, 3);
    repeat (6) tick();
    checks++;
    if (rd_pops != pops0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL short_no_start pops=%0d busy=%b want 0/0", rd_pops - pops0, busy);
    end
    flush = 1'b1;
    for (int k = 0; k < 10 && !busy; k++) tick();
    for (int k = 0; k < 40 && busy; k++) tick();
    flush = 1'b0; enable = 1'b0;
    checks++;
    if (busy !== 1'b0 || rd_pops - pops0 != 3) begin
      errors++;
      $display("FAIL short_done busy=%b pops=%0d want 0/3", busy, rd_pops - pops0);
    end
    checks++;
    if (got_d.size() != 3) begin
      errors++; $display("FAIL short_count got %0d words want 3", got_d.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (got_d[i] !== 32'(i + 5) || got_l[i] !== (i == 2)) begin
          errors++;
          $display("FAIL short_word%0d got %0d/last=%b want %0d/last=%b",
                   i, got_d[i], got_l[i], i + 5, (i == 2));
        end
      end
    end
  endtask

  task automatic test_stall();
    int pops0;
    got_d.delete(); got_l.delete();
    m_ready = 1'b0;
    pops0   = rd_pops;
    write_words(32'd10, 4);
    enable = 1'b1;
    tick();
    enable = 1'b0;
    repeat (8) tick();
    checks++;
    if (rd_pops - pops0 != 3) begin
      errors++; $display("FAIL stall_pops got %0d want 3", rd_pops - pops0);
    end
    checks++;
    if (m_valid !== 1'b1 || m_data !== 32'd10 || m_last !== 1'b0 || fifo_rd_en !== 1'b0) begin
      errors++;
      $display("FAIL stall_head valid=%b data=%0d last=%b rd_en=%b want 1/10/0/0",
               m_valid, m_data, m_last, fifo_rd_en);
    end
    repeat (3) tick();
    checks++;
    if (m_valid !== 1'b1 || m_data !== 32'd10) begin
      errors++; $display("FAIL stall_hold valid=%b data=%0d want 1/10", m_valid, m_data);
    end
    m_ready = 1'b1;
    for (int k = 0; k < 40 && busy; k++) tick();
    checks++;
    if (busy !== 1'b0 || rd_pops - pops0 != 4) begin
      errors++;
      $display("FAIL stall_resume busy=%b pops=%0d want 0/4", busy, rd_pops - pops0);
    end
    checks++;
    if (got_d.size() != 4) begin
      errors++; $display("FAIL stall_count got %0d words want 4", got_d.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (got_d[i] !== 32'(i + 10) || got_l[i] !== (i == 3)) begin
          errors++;
          $display("FAIL stall_word%0d got %0d/last=%b want %0d/last=%b",
                   i, got_d[i], got_l[i], i + 10, (i == 3));
        end
      end
    end
  endtask

  task automatic test_mid_burst_reset();
    int pops0;
    m_ready = 1'b1;
    write_words(32'd20, 4);
    enable = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b1;
    #1;
    checks++;
    if ({fifo_rd_en, m_valid, m_last, busy} !== 4'b0000 || m_data !== 32'd0) begin
      errors++;
      $display("FAIL midreset_outputs rd_en=%b valid=%b last=%b busy=%b data=%h, want all 0",
               fifo_rd_en, m_valid, m_last, busy, m_data);
    end
    enable = 1'b0;
    #1 rst = 1'b0;
    pops0 = rd_pops;
    repeat (6) tick();
    checks++;
    if (rd_pops != pops0 || busy !== 1'b0 || m_valid !== 1'b0) begin
      errors++;
      $display("FAIL midreset_idle pops=%0d busy=%b valid=%b want 0/0/0",
               rd_pops - pops0, busy, m_valid);
    end
  endtask

  task automatic test_empty_flush();
    int  pops0;
    bit  saw_busy;
    pops0    = rd_pops;
    saw_busy = 1'b0;
    flush    = 1'b1;
    for (int k = 0; k < 8; k++) begin
      tick();
      if (busy) saw_busy = 1'b1;
    end
    flush = 1'b0;
    checks++;
    if (rd_pops != pops0 || saw_busy) begin
      errors++;
      $display("FAIL empty_flush pops=%0d busy_seen=%b want 0/0", rd_pops - pops0, saw_busy);
    end
  endtask

  task automatic test_back_to_back();
    bit [15:0] rd_h;
    got_d.delete(); got_l.delete();
    m_ready = 1'b1;
    write_words(32'd30, 8);
    enable = 1'b1;
    @(posedge clk);
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      rd_h[i] = fifo_rd_en;
    end
    tick(); enable = 1'b0;
    for (int k = 0; k < 40 && busy; k++) tick();
    checks++;
    if (rd_h !== 16'b0000_1111_0000_1111) begin
      errors++;
      $display("FAIL b2b_rd_en_pattern got %b want %b", rd_h, 16'b0000_1111_0000_1111);
    end
    checks++;
    if (got_d.size() != 8) begin
      errors++; $display("FAIL b2b_count got %0d words want 8", got_d.size());
    end else begin
      for (int i = 0; i < 8; i++) begin
        checks++;
        if (got_d[i] !== 32'(i + 30) || got_l[i] !== (i == 3 || i == 7)) begin
          errors++;
          $display("FAIL b2b_word%0d got %0d/last=%b want %0d/last=%b",
                   i, got_d[i], got_l[i], i + 30, (i == 3 || i == 7));
        end
      end
    end
  endtask

`ifdef FIFO_READER_STATS_EN
  task automatic test_stats();
    checks++;
    if (rd_count !== 16'd8) begin
      errors++; $display("FAIL stats_count got %0d want 8", rd_count);
    end
    tick();
    force dut.rd_count_q = 16'hFFFF;
    #1 release dut.rd_count_q;
    m_ready = 1'b1;
    write_words(32'd40, 1);
    flush = 1'b1;
    for (int k = 0; k < 10 && !busy; k++) tick();
    for (int k = 0; k < 40 && busy; k++) tick();
    flush = 1'b0;
    checks++;
    if (rd_count !== 16'd0) begin
      errors++; $display("FAIL stats_wrap got %0d want 0", rd_count);
    end
  endtask
`endif

  task automatic test_no_underflow();
    checks++;
    if (underflow != 0) begin
      errors++; $display("FAIL underflow got %0d pops while empty want 0", underflow);
    end
  endtask

  initial begin
    rst = 1'b1; enable = 1'b0; flush = 1'b0; m_ready = 1'b0;
    wr_en = 1'b0; wr_data = '0;
    repeat (3) @(posedge clk);
    test_reset();
    #2 rst = 1'b0;
    tick();
    test_full_burst();
    test_flush_short();
    test_stall();
    test_mid_burst_reset();
    test_empty_flush();
    test_back_to_back();
`ifdef FIFO_READER_STATS_EN
    test_stats();
`endif
    test_no_underflow();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

endmodule
